// File: rtl/nfca_rx_frame_buffer_pkg.sv
// ============================================================================
// Module  : nfca_rx_frame_buffer_pkg
// Purpose : Shared ISO14443-A constants and storage word layout for the
//           NFC-A receive frame buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package nfca_rx_frame_buffer_pkg;

    localparam logic [15:0] CRCA_INIT      = 16'h6363;
    localparam logic [15:0] CRCA_POLY_REFL = 16'h8408;
    localparam logic [3:0]  NFCA_FULL_BYTE = 4'd8;
    localparam int unsigned RAM_W          = 12;

    // One buffered byte: valid-bit count kept alongside the data.
    typedef struct packed {
        logic [3:0] datab;
        logic [7:0] data;
    } rx_word_t;

endpackage

`default_nettype wire

// File: rtl/nfca_rx_frame_buffer_if.sv
// ============================================================================
// Module  : nfca_rx_frame_buffer_if
// Purpose : Receive byte stream in, host byte stream and frame status out.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface nfca_rx_frame_buffer_if #(
    parameter int AW = 6
);
    logic          rx_tvalid;
    logic [7:0]    rx_tdata;
    logic [3:0]    rx_tdatab;
    logic          rx_tend;
    logic          rx_terr;
    logic          m_tvalid;
    logic          m_tready;
    logic [7:0]    m_tdata;
    logic [3:0]    m_tdatab;
    logic          m_tlast;
    logic          st_valid;
    logic [AW:0]   st_len;
    logic          st_crc_ok;
    logic          st_err;
    logic          st_ovf;
    logic          drop_pulse;

    // Master: the receiver/host environment around the buffer.
    modport master (
        output rx_tvalid, rx_tdata, rx_tdatab, rx_tend, rx_terr, m_tready,
        input  m_tvalid, m_tdata, m_tdatab, m_tlast,
        input  st_valid, st_len, st_crc_ok, st_err, st_ovf, drop_pulse
    );

    modport slave (
        input  rx_tvalid, rx_tdata, rx_tdatab, rx_tend, rx_terr, m_tready,
        output m_tvalid, m_tdata, m_tdatab, m_tlast,
        output st_valid, st_len, st_crc_ok, st_err, st_ovf, drop_pulse
    );
endinterface

`default_nettype wire

// File: rtl/nfca_rx_buf_ram.sv
// ============================================================================
// Module  : nfca_rx_buf_ram
// Purpose : Simple dual-port frame RAM with a registered read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nfca_rx_buf_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int W     = 12
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register only advances on rd_en so the presented word holds during stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/nfca_rx_frame_buffer.sv
// ============================================================================
// Module  : nfca_rx_frame_buffer
// Purpose : Captures one NFC-A receive frame, checks CRC_A and replays it to
//           the host as a ready/valid byte stream with a status word.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nfca_rx_frame_buffer
    import nfca_rx_frame_buffer_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic                    clk,
    input  logic                    rstn,
    nfca_rx_frame_buffer_if.slave   bus
);
    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_CAPTURE = 2'd1;
    localparam logic [1:0]  ST_DRAIN   = 2'd2;
    localparam logic [AW:0] LEN_FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0] LEN_MIN    = (AW+1)'(3);

    function automatic logic [15:0] crca_step(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRCA_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    logic [1:0]  state_q,      state_d;
    logic [AW:0] wr_ptr_q,     wr_ptr_d;
    logic [AW:0] rd_ptr_q,     rd_ptr_d;
    logic [15:0] crc_q,        crc_d;
    logic        part_q,       part_d;
    logic        ovf_q,        ovf_d;
    logic        drop_act_q,   drop_act_d;
    logic        m_tvalid_q,   m_tvalid_d;
    logic        st_valid_q,   st_valid_d;
    logic [AW:0] st_len_q,     st_len_d;
    logic        st_crc_ok_q,  st_crc_ok_d;
    logic        st_err_q,     st_err_d;
    logic        st_ovf_q,     st_ovf_d;
    logic        drop_pulse_q, drop_pulse_d;

    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          accept;
    logic          last;
    rx_word_t      wr_word;
    rx_word_t      rd_word;

    assign accept  = (state_q != ST_DRAIN) && !drop_act_q;
    assign last    = (rd_ptr_q == (st_len_q - 1'b1));
    assign wr_word = '{datab: bus.rx_tdatab, data: bus.rx_tdata};

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        crc_d        = crc_q;
        part_d       = part_q;
        ovf_d        = ovf_q;
        drop_act_d   = drop_act_q;
        m_tvalid_d   = m_tvalid_q;
        st_valid_d   = st_valid_q;
        st_len_d     = st_len_q;
        st_crc_ok_d  = st_crc_ok_q;
        st_err_d     = st_err_q;
        st_ovf_d     = st_ovf_q;
        drop_pulse_d = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        rd_addr      = rd_ptr_q[AW-1:0];

        if (accept) begin
            if (bus.rx_tvalid) begin
                if (wr_ptr_q != LEN_FULL) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (bus.rx_tdatab == NFCA_FULL_BYTE) begin
                        crc_d = crca_step(crc_q, bus.rx_tdata);
                    end else begin
                        part_d = 1'b1;
                    end
                end else begin
                    ovf_d = 1'b1;
                end
                if (state_q == ST_IDLE) begin
                    state_d = ST_CAPTURE;
                end
            end
            // Status is taken from the next-state values so a byte sharing the rx_tend cycle counts.
            if (bus.rx_tend) begin
                state_d     = ST_DRAIN;
                st_valid_d  = 1'b1;
                st_len_d    = wr_ptr_d;
                st_crc_ok_d = (crc_d == 16'h0000) && !part_d && (wr_ptr_d >= LEN_MIN);
                st_err_d    = bus.rx_terr;
                st_ovf_d    = ovf_d;
                rd_ptr_d    = '0;
            end
        end else begin
            // A frame that started while busy is ignored through its own rx_tend.
            if (bus.rx_tend) begin
                drop_pulse_d = 1'b1;
                drop_act_d   = 1'b0;
            end else if (bus.rx_tvalid) begin
                drop_act_d   = 1'b1;
            end
        end

        if (state_q == ST_DRAIN) begin
            if (!m_tvalid_q) begin
                if (st_len_q == '0) begin
                    state_d    = ST_IDLE;
                    st_valid_d = 1'b0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    crc_d      = CRCA_INIT;
                    part_d     = 1'b0;
                    ovf_d      = 1'b0;
                end else begin
                    rd_en      = 1'b1;
                    m_tvalid_d = 1'b1;
                end
            end else if (bus.m_tready) begin
                if (last) begin
                    state_d    = ST_IDLE;
                    m_tvalid_d = 1'b0;
                    st_valid_d = 1'b0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    crc_d      = CRCA_INIT;
                    part_d     = 1'b0;
                    ovf_d      = 1'b0;
                end else begin
                    // Prefetch the next byte so it lands exactly as this one is consumed.
                    rd_en    = 1'b1;
                    rd_addr  = rd_ptr_q[AW-1:0] + {{(AW-1){1'b0}}, 1'b1};
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            crc_q        <= CRCA_INIT;
            part_q       <= 1'b0;
            ovf_q        <= 1'b0;
            drop_act_q   <= 1'b0;
            m_tvalid_q   <= 1'b0;
            st_valid_q   <= 1'b0;
            st_len_q     <= '0;
            st_crc_ok_q  <= 1'b0;
            st_err_q     <= 1'b0;
            st_ovf_q     <= 1'b0;
            drop_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            crc_q        <= crc_d;
            part_q       <= part_d;
            ovf_q        <= ovf_d;
            drop_act_q   <= drop_act_d;
            m_tvalid_q   <= m_tvalid_d;
            st_valid_q   <= st_valid_d;
            st_len_q     <= st_len_d;
            st_crc_ok_q  <= st_crc_ok_d;
            st_err_q     <= st_err_d;
            st_ovf_q     <= st_ovf_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    nfca_rx_buf_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (RAM_W)
    ) u_ram (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (wr_word),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_word)
    );

    assign bus.m_tvalid   = m_tvalid_q;
    assign bus.m_tdata    = rd_word.data;
    assign bus.m_tdatab   = rd_word.datab;
    assign bus.m_tlast    = m_tvalid_q && last;
    assign bus.st_valid   = st_valid_q;
    assign bus.st_len     = st_len_q;
    assign bus.st_crc_ok  = st_crc_ok_q;
    assign bus.st_err     = st_err_q;
    assign bus.st_ovf     = st_ovf_q;
    assign bus.drop_pulse = drop_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_nfca_rx_frame_buffer.sv
// ============================================================================
// Module  : tb_nfca_rx_frame_buffer
// Purpose : Directed self-checking bench for the NFC-A receive frame buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nfca_rx_frame_buffer;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_errors;
    int   g_drops;
    logic [7:0] exp_d [0:127];
    logic [3:0] exp_b [0:127];

    nfca_rx_frame_buffer_if #(.AW(AW)) bus ();

    nfca_rx_frame_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n, input bit tend_last, input bit terr);
        for (int i = 0; i < n; i++) begin
            bus.rx_tvalid = 1'b1;
            bus.rx_tdata  = exp_d[i];
            bus.rx_tdatab = exp_b[i];
            bus.rx_tend   = tend_last && (i == n - 1);
            bus.rx_terr   = tend_last && (i == n - 1) && terr;
            tick();
        end
        bus.rx_tvalid = 1'b0;
        if (!tend_last || n == 0) begin
            bus.rx_tend = 1'b1;
            bus.rx_terr = terr;
            tick();
        end
        bus.rx_tend = 1'b0;
        bus.rx_terr = 1'b0;
    endtask

    // Expects st_valid high and no data yet; crc < 0 skips the CRC comparison.
    task automatic check_status(input string tag, input int len, input int crc,
                                input int err, input int ovf);
        chk({tag, "_st_valid"}, 32'(bus.st_valid), 32'd1);
        chk({tag, "_early_tvalid"}, 32'(bus.m_tvalid), 32'd0);
        chk({tag, "_st_len"}, 32'(bus.st_len), 32'(len));
        if (crc >= 0) chk({tag, "_crc_ok"}, 32'(bus.st_crc_ok), 32'(crc));
        chk({tag, "_err"}, 32'(bus.st_err), 32'(err));
        chk({tag, "_ovf"}, 32'(bus.st_ovf), 32'(ovf));
        tick();
        chk({tag, "_first_tvalid"}, 32'(bus.m_tvalid), 32'd1);
    endtask

    task automatic drain(input string tag, input int n, input int pct, input bit inject);
        int          k       = 0;
        int          cyc     = 0;
        bit          stalled = 1'b0;
        bit          rdy;
        logic [11:0] held    = '0;
        while (k < n && cyc < 3000) begin
            rdy           = ($urandom_range(0, 99) < pct);
            bus.rx_tvalid = inject && cyc >= 2 && cyc <= 6;
            bus.rx_tdata  = 8'hA0 + 8'(cyc);
            bus.rx_tdatab = 4'd8;
            bus.rx_tend   = inject && cyc == 7;
            if (stalled) begin
                chk({tag, "_stall_hold"}, {19'b0, bus.m_tvalid, bus.m_tdatab, bus.m_tdata},
                    {19'b0, 1'b1, held});
            end
            stalled = 1'b0;
            if (bus.m_tvalid) begin
                if (rdy) begin
                    chk({tag, "_data"}, 32'(bus.m_tdata), 32'(exp_d[k]));
                    chk({tag, "_datab"}, 32'(bus.m_tdatab), 32'(exp_b[k]));
                    chk({tag, "_tlast"}, 32'(bus.m_tlast), 32'(k == n - 1));
                    k++;
                end else begin
                    stalled = 1'b1;
                    held    = {bus.m_tdatab, bus.m_tdata};
                end
            end
            bus.m_tready = rdy;
            tick();
            g_drops += int'(bus.drop_pulse);
            cyc++;
        end
        bus.rx_tvalid = 1'b0;
        bus.rx_tend   = 1'b0;
        bus.m_tready  = 1'b0;
        chk({tag, "_byte_count"}, 32'(k), 32'(n));
        chk({tag, "_end_st_valid"}, 32'(bus.st_valid), 32'd0);
        chk({tag, "_end_tvalid"}, 32'(bus.m_tvalid), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk(tag, {6'b0, bus.m_tvalid, bus.m_tdata, bus.m_tdatab, bus.m_tlast, bus.st_valid,
                  bus.st_len, bus.st_crc_ok, bus.st_err, bus.st_ovf, bus.drop_pulse}, 32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        g_drops       = 0;
        rstn          = 1'b0;
        bus.rx_tvalid = 1'b0;
        bus.rx_tdata  = 8'h00;
        bus.rx_tdatab = 4'd8;
        bus.rx_tend   = 1'b0;
        bus.rx_terr   = 1'b0;
        bus.m_tready  = 1'b0;
        for (int i = 0; i < 128; i++) begin
            exp_d[i] = 8'h00;
            exp_b[i] = 4'd8;
        end
        tick();
        tick();
        check_outputs_zero("reset_outputs");
        rstn = 1'b1;
        tick();

        // ATQA 44 00: two bytes, too short for a CRC
        exp_d[0] = 8'h44; exp_d[1] = 8'h00;
        send(2, 1'b1, 1'b0);
        check_status("atqa", 2, 0, 0, 0);
        drain("atqa", 2, 100, 1'b0);

        // SAK 08 with valid CRC_A B6 DD, rx_tend on its own cycle
        exp_d[0] = 8'h08; exp_d[1] = 8'hB6; exp_d[2] = 8'hDD;
        send(3, 1'b0, 1'b0);
        check_status("sak_ok", 3, 1, 0, 0);
        drain("sak_ok", 3, 100, 1'b0);

        // Corrupted CRC byte
        exp_d[2] = 8'hDC;
        send(3, 1'b1, 1'b0);
        check_status("sak_bad", 3, 0, 0, 0);
        drain("sak_bad", 3, 100, 1'b0);

        // Overflow: DEPTH+3 bytes, only DEPTH kept
        for (int i = 0; i < DEPTH + 3; i++) exp_d[i] = 8'(i);
        send(DEPTH + 3, 1'b1, 1'b0);
        check_status("ovf", DEPTH, -1, 0, 1);
        drain("ovf", DEPTH, 100, 1'b0);

        // Single 4-bit partial byte with coding error
        exp_d[0] = 8'h0A; exp_b[0] = 4'd4;
        send(1, 1'b1, 1'b1);
        check_status("partial", 1, 0, 1, 0);
        drain("partial", 1, 100, 1'b0);
        exp_b[0] = 4'd8;

        // Empty frame: status pulses one cycle, no data
        send(0, 1'b0, 1'b0);
        chk("empty_st_valid", 32'(bus.st_valid), 32'd1);
        chk("empty_st_len", 32'(bus.st_len), 32'd0);
        chk("empty_tvalid", 32'(bus.m_tvalid), 32'd0);
        tick();
        chk("empty_st_valid_drop", 32'(bus.st_valid), 32'd0);
        chk("empty_tvalid_after", 32'(bus.m_tvalid), 32'd0);

        // Back-pressured drain with a second frame arriving while busy
        for (int i = 0; i < 16; i++) exp_d[i] = 8'h30 + 8'(i * 7);
        g_drops = 0;
        send(16, 1'b1, 1'b0);
        check_status("busy", 16, 0, 0, 0);
        drain("busy", 16, 30, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            g_drops += int'(bus.drop_pulse);
        end
        chk("busy_drop_count", 32'(g_drops), 32'd1);
        chk("busy_no_second_frame", {30'b0, bus.m_tvalid, bus.st_valid}, 32'd0);

        // Asynchronous reset mid-frame, then a clean SAK frame
        for (int i = 0; i < 5; i++) begin
            bus.rx_tvalid = 1'b1;
            bus.rx_tdata  = 8'h11 * 8'(i + 1);
            bus.rx_tdatab = 4'd8;
            tick();
        end
        bus.rx_tvalid = 1'b0;
        #2 rstn = 1'b0;
        #1 check_outputs_zero("midframe_reset");
        tick();
        rstn = 1'b1;
        tick();
        exp_d[0] = 8'h08; exp_d[1] = 8'hB6; exp_d[2] = 8'hDD;
        send(3, 1'b1, 1'b0);
        check_status("post_reset", 3, 1, 0, 0);
        drain("post_reset", 3, 100, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
